// File: rtl/next_pc_unit_pkg.sv
// Shared encodings for the next-PC stage: command opcodes and sequencer states.
package next_pc_unit_pkg;

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

endpackage

// File: rtl/next_pc_unit_ras_stack.sv
// Return-address LIFO: push/pop one entry per cycle, top-of-stack and occupancy flags.
module next_pc_unit_ras_stack #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W:0]    r_sp;
  logic [PTR_W-1:0]  w_top_idx;

  // The pointer is one wider than the index so full and empty are distinguishable.
  assign w_top_idx = PTR_W'(r_sp - (PTR_W+1)'(1));
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_sp == '0);
  assign o_full    = (r_sp == (PTR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !o_full) begin
      r_mem[r_sp[PTR_W-1:0]] <= i_data;
      r_sp <= r_sp + (PTR_W+1)'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-address stage with RUN/HALT/FAULT sequencing; NEXT_PC_RAS_EN builds the
// return-address stack, otherwise CALL acts as JMP and RET faults.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic [2:0]        op,
  input  logic              cond,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] target,
  input  logic              stall,
  input  logic              resume,
  output logic [ADDR_W-1:0] next,
  output logic              halted,
  output logic              fault,
  output logic              ras_empty,
  output logic              ras_full
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two and at least 2");
  end

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_br;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_full;
`ifdef NEXT_PC_RAS_EN
  logic              w_push;
  logic              w_pop;
`endif

  // Two's-complement add in ADDR_W bits is the same as sign-extend-then-wrap.
  assign w_seq = pc + ONE;
  assign w_br  = pc + offset;

  always_comb begin
    w_next      = w_seq;
    w_state_nxt = r_state;
`ifdef NEXT_PC_RAS_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
`endif
    case (r_state)
      ST_FAULT: w_next = pc;
      ST_HALT: begin
        w_next = pc;
        if (resume) w_state_nxt = ST_RUN;
      end
      default: begin
        if (stall) begin
          w_next = pc;
        end else begin
          case (op)
            OP_BR:  if (cond) w_next = w_br;
            OP_JMP: w_next = target;
            OP_CALL: begin
              if (w_ras_full) begin
                w_next      = pc;
                w_state_nxt = ST_FAULT;
              end else begin
                w_next = target;
`ifdef NEXT_PC_RAS_EN
                w_push = 1'b1;
`endif
              end
            end
            OP_RET: begin
              if (w_ras_empty) begin
                w_next      = pc;
                w_state_nxt = ST_FAULT;
              end else begin
                w_next = w_ras_top;
`ifdef NEXT_PC_RAS_EN
                w_pop  = 1'b1;
`endif
              end
            end
            OP_HALT: begin
              w_next      = pc;
              w_state_nxt = ST_HALT;
            end
            default: w_next = w_seq;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

`ifdef NEXT_PC_RAS_EN
  next_pc_unit_ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_seq),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full)
  );
`else
  // Without a stack, an always-empty/never-full view gives CALL=JMP and RET=FAULT.
  assign w_ras_top   = '0;
  assign w_ras_empty = 1'b1;
  assign w_ras_full  = 1'b0;
`endif

  assign next      = w_next;
  assign halted    = (r_state == ST_HALT);
  assign fault     = (r_state == ST_FAULT);
  assign ras_empty = w_ras_empty;
  assign ras_full  = w_ras_full;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: spec-level model checked every cycle plus directed literal checks.
module tb_next_pc_unit;

  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int MOD   = 16;
`ifdef NEXT_PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc, offset, target;
  logic [2:0]    op;
  logic          cond, stall, resume;
  logic [AW-1:0] next;
  logic          halted, fault, ras_empty, ras_full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  next_pc_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .op(op), .cond(cond), .offset(offset),
    .target(target), .stall(stall), .resume(resume), .next(next),
    .halted(halted), .fault(fault), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  // Model: 0=run, 1=halt, 2=fault; stack as an int array with a count.
  int m_state = 0;
  int m_cnt   = 0;
  int m_stack [DEPTH];

  function automatic int m_next();
    int soff;
    soff = (int'(offset) >= MOD/2) ? int'(offset) - MOD : int'(offset);
    if (m_state != 0 || stall) return int'(pc);
    case (int'(op))
      1: return cond ? (int'(pc) + soff + MOD) % MOD : (int'(pc) + 1) % MOD;
      2: return int'(target);
      3: return (RAS_ON && m_cnt == DEPTH) ? int'(pc) : int'(target);
      4: return (RAS_ON && m_cnt > 0) ? m_stack[m_cnt-1] : int'(pc);
      5: return int'(pc);
      default: return (int'(pc) + 1) % MOD;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_cnt   <= 0;
      for (int i = 0; i < DEPTH; i++) m_stack[i] <= 0;
    end else if (m_state == 1) begin
      if (resume) m_state <= 0;
    end else if (m_state == 0 && !stall) begin
      case (int'(op))
        3: if (RAS_ON) begin
             if (m_cnt == DEPTH) m_state <= 2;
             else begin
               m_stack[m_cnt] <= (int'(pc) + 1) % MOD;
               m_cnt <= m_cnt + 1;
             end
           end
        4: if (RAS_ON && m_cnt > 0) m_cnt <= m_cnt - 1;
           else m_state <= 2;
        5: m_state <= 1;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_next", int'(next), m_next());
    check("model_halted", int'(halted), int'(m_state == 1));
    check("model_fault", int'(fault), int'(m_state == 2));
    check("model_empty", int'(ras_empty), int'(m_cnt == 0));
    check("model_full", int'(ras_full), int'(m_cnt == DEPTH));
  end

  task automatic drv(input logic [2:0] o, input int p, input logic c = 1'b0,
                     input int off = 0, input int tgt = 0,
                     input logic st = 1'b0, input logic rs = 1'b0);
    op = o; pc = AW'(p); cond = c; offset = AW'(off); target = AW'(tgt);
    stall = st; resume = rs;
    #2;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_fault", int'(fault), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_empty", int'(ras_empty), 1);
    check("rst_full", int'(ras_full), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(3'b000, 5);
    check("reset_next", int'(next), 6);
    check("reset_halted", int'(halted), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_empty", int'(ras_empty), 1);
    check("reset_full", int'(ras_full), 0);
    rst_n = 1'b1;
    edge_step();

    for (int p = 0; p < 16; p++) begin
      drv(3'b000, p);
      check("seq_next", int'(next), (p == 15) ? 0 : p + 1);
      edge_step();
    end

    drv(3'b001, 2, 1'b1, 14);  check("br_taken_neg", int'(next), 0);
    drv(3'b001, 2, 1'b0, 14);  check("br_not_taken", int'(next), 3);
    drv(3'b001, 14, 1'b1, 3);  check("br_wrap", int'(next), 1);
    drv(3'b110, 9);            check("op110_seq", int'(next), 10);
    drv(3'b010, 4, 1'b0, 0, 11); check("jmp", int'(next), 11);
    drv(3'b010, 3, 1'b0, 0, 12, 1'b1); check("stall_jmp", int'(next), 3);
    edge_step();

`ifdef NEXT_PC_RAS_EN
    drv(3'b011, 3, 1'b0, 0, 9); check("call_next", int'(next), 9);
    edge_step();
    drv(3'b100, 9); check("call_empty", int'(ras_empty), 0);
    check("ret_next", int'(next), 4);
    edge_step();
    drv(3'b000, 4); check("ret_empty", int'(ras_empty), 1);
    edge_step();
    for (int i = 0; i < 4; i++) begin
      drv(3'b011, i, 1'b0, 0, 8);
      edge_step();
    end
    drv(3'b011, 5, 1'b0, 0, 8);
    check("full_flag", int'(ras_full), 1);
    check("overflow_next", int'(next), 5);
    edge_step();
    drv(3'b000, 7); check("overflow_fault", int'(fault), 1);
    check("fault_hold", int'(next), 7);
    edge_step();
    drv(3'b100, 7); check("fault_ret_ignored", int'(next), 7);
    rst_pulse();
    edge_step();
`else
    drv(3'b011, 3, 1'b0, 0, 9); check("call_as_jmp", int'(next), 9);
    edge_step();
    drv(3'b100, 9); check("call_no_push", int'(ras_empty), 1);
    check("ret_next", int'(next), 9);
    edge_step();
    drv(3'b000, 9); check("ret_fault", int'(fault), 1);
    check("fault_hold", int'(next), 9);
    rst_pulse();
    edge_step();
`endif

    drv(3'b101, 6); check("halt_next", int'(next), 6);
    edge_step();
    for (int i = 0; i < 3; i++) begin
      drv(3'b000, 6);
      check("halted_flag", int'(halted), 1);
      check("halted_next", int'(next), 6);
      edge_step();
    end
    drv(3'b000, 6, 1'b0, 0, 0, 1'b0, 1'b1); check("resume_next", int'(next), 6);
    edge_step();
    drv(3'b000, 6); check("resumed", int'(halted), 0);
    check("resumed_next", int'(next), 7);
    edge_step();

`ifdef NEXT_PC_RAS_EN
    drv(3'b011, 1, 1'b0, 0, 9);
    edge_step();
    drv(3'b100, 9, 1'b0, 0, 0, 1'b1); check("stall_ret_next", int'(next), 9);
    edge_step();
    drv(3'b100, 9); check("stall_ret_empty", int'(ras_empty), 0);
    check("ret_after_stall", int'(next), 2);
    edge_step();
    drv(3'b000, 2); check("ret_after_stall_empty", int'(ras_empty), 1);
    edge_step();
    drv(3'b011, 0, 1'b0, 0, 5);
    edge_step();
    drv(3'b011, 5, 1'b0, 0, 6); check("mid_call_empty", int'(ras_empty), 0);
    rst_pulse();
    drv(3'b100, 6); check("ret_after_clear", int'(next), 6);
    edge_step();
    drv(3'b000, 6); check("ret_after_clear_fault", int'(fault), 1);
    rst_pulse();
    edge_step();
`endif

    drv(3'b000, 0);
    edge_step();
    edge_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
